// File: rtl/common_pkg.sv
// Shared types for the vgacpu raster path: GPU opcodes and command-queue dispatcher states.
package common;

  typedef enum logic [2:0] {
    RC_NOP         = 3'd0,
    RC_POINT       = 3'd1,
    RC_LINE        = 3'd2,
    RC_RECT        = 3'd3,
    RC_FILL_RECT   = 3'd4,
    RC_CIRCLE      = 3'd5,
    RC_FILL_CIRCLE = 3'd6,
    RC_CLEAR       = 3'd7
  } raster_command_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    HOLDOFF = 2'd2,
    WAIT    = 2'd3
  } cmdq_state_t;

endpackage

// File: rtl/gpu_cmd_queue_fifo.sv
// Synchronous FIFO with flush and an explicit occupancy register; read data is the
// combinational head entry so the dispatcher can capture and pop it on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_async,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  // Full is judged on the registered count, so a pop on the same edge never rescues a push.
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; stale slots are unreachable once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/gpu_cmd_queue.sv
// Buffers CPU raster commands and issues them one at a time to the GPU as single-cycle
// execute pulses, waiting out the GPU's registered busy latency between issues.
module gpu_cmd_queue
  import common::*;
#(
  parameter int DEPTH    = 8,
  parameter int COORD_W  = 8,
  parameter int COLOUR_W = 3
) (
  input  logic                         clk,
  input  logic                         rst_async,
  input  logic                         push,
  input  raster_command_t              in_command,
  input  logic [COORD_W-1:0]           in_x0,
  input  logic [COORD_W-1:0]           in_y0,
  input  logic [COORD_W-1:0]           in_x1,
  input  logic [COORD_W-1:0]           in_y1,
  input  logic [COLOUR_W-1:0]          in_colour,
  input  logic                         flush,
  input  logic                         clear_overflow,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output raster_command_t              gpu_command,
  output logic [COORD_W-1:0]           gpu_x0,
  output logic [COORD_W-1:0]           gpu_y0,
  output logic [COORD_W-1:0]           gpu_x1,
  output logic [COORD_W-1:0]           gpu_y1,
  output logic [COLOUR_W-1:0]          gpu_colour,
  output logic                         gpu_execute_request,
  input  logic                         gpu_busy
);

  typedef struct packed {
    raster_command_t       command;
    logic [COORD_W-1:0]    x0;
    logic [COORD_W-1:0]    y0;
    logic [COORD_W-1:0]    x1;
    logic [COORD_W-1:0]    y1;
    logic [COLOUR_W-1:0]   colour;
  } entry_t;

  entry_t      wr_entry, rd_entry, gpu_q;
  cmdq_state_t state_q;
  logic        req_q;
  logic        overflow_q;
  logic        pop;

  assign wr_entry = '{command: in_command, x0: in_x0, y0: in_y0,
                      x1: in_x1, y1: in_y1, colour: in_colour};
  assign pop      = (state_q == IDLE) && !empty && !gpu_busy;

  sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_async (rst_async),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .wdata     (wr_entry),
    .rdata     (rd_entry),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // A dropped push outranks clear; a flush-killed push is intentional and never flags.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      overflow_q <= 1'b0;
    end else if (push && full && !flush) begin
      overflow_q <= 1'b1;
    end else if (clear_overflow) begin
      overflow_q <= 1'b0;
    end
  end

  // HOLDOFF skips the first post-issue cycle, where the GPU has not yet raised busy.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      gpu_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!empty && !gpu_busy) begin
            gpu_q   <= rd_entry;
            req_q   <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          req_q   <= 1'b0;
          state_q <= HOLDOFF;
        end
        HOLDOFF: begin
          state_q <= WAIT;
        end
        WAIT: begin
          if (!gpu_busy) state_q <= IDLE;
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign overflow            = overflow_q;
  assign gpu_execute_request = req_q;
  assign gpu_command         = gpu_q.command;
  assign gpu_x0              = gpu_q.x0;
  assign gpu_y0              = gpu_q.y0;
  assign gpu_x1              = gpu_q.x1;
  assign gpu_y1              = gpu_q.y1;
  assign gpu_colour          = gpu_q.colour;

endmodule

// File: tb/tb_gpu_cmd_queue.sv
// Scoreboard bench for gpu_cmd_queue: accepted pushes queue expected entries, a negedge
// monitor captures every execute pulse and drives a simple busy-after-request GPU model.
module tb_gpu_cmd_queue;
  import common::*;

  localparam int DEPTH    = 8;
  localparam int COORD_W  = 8;
  localparam int COLOUR_W = 3;
  localparam int CNT_W    = $clog2(DEPTH+1);
  localparam int ENT_W    = $bits(raster_command_t) + 4*COORD_W + COLOUR_W;

  logic                  clk = 1'b0;
  logic                  rst_async = 1'b1;
  logic                  push = 1'b0;
  raster_command_t       in_command = RC_NOP;
  logic [COORD_W-1:0]    in_x0 = '0, in_y0 = '0, in_x1 = '0, in_y1 = '0;
  logic [COLOUR_W-1:0]   in_colour = '0;
  logic                  flush = 1'b0;
  logic                  clear_overflow = 1'b0;
  logic                  full, empty, overflow;
  logic [CNT_W-1:0]      count;
  raster_command_t       gpu_command;
  logic [COORD_W-1:0]    gpu_x0, gpu_y0, gpu_x1, gpu_y1;
  logic [COLOUR_W-1:0]   gpu_colour;
  logic                  gpu_execute_request;
  logic                  gpu_busy;

  int vecCount = 0;
  int errCount = 0;

  logic [ENT_W-1:0] expQ[$];
  logic [ENT_W-1:0] obsQ[$];
  int               pulseCycle[$];
  int               readIdx = 0;
  int               cycleNo = 0;
  int               busyViol = 0;
  int               b2bViol = 0;
  bit               prevReq = 1'b0;
  int               busyCnt = 0;
  int               busyLen = 0;
  bit               forceBusy = 1'b0;

  assign gpu_busy = forceBusy || (busyCnt != 0);

  always #10 clk = ~clk;

  gpu_cmd_queue #(.DEPTH(DEPTH), .COORD_W(COORD_W), .COLOUR_W(COLOUR_W)) dut (
    .clk                 (clk),
    .rst_async           (rst_async),
    .push                (push),
    .in_command          (in_command),
    .in_x0               (in_x0),
    .in_y0               (in_y0),
    .in_x1               (in_x1),
    .in_y1               (in_y1),
    .in_colour           (in_colour),
    .flush               (flush),
    .clear_overflow      (clear_overflow),
    .full                (full),
    .empty               (empty),
    .count               (count),
    .overflow            (overflow),
    .gpu_command         (gpu_command),
    .gpu_x0              (gpu_x0),
    .gpu_y0              (gpu_y0),
    .gpu_x1              (gpu_x1),
    .gpu_y1              (gpu_y1),
    .gpu_colour          (gpu_colour),
    .gpu_execute_request (gpu_execute_request),
    .gpu_busy            (gpu_busy)
  );

  // GPU model: busy rises right after a request is seen and lasts busyLen cycles.
  always @(negedge clk) begin
    cycleNo++;
    if (gpu_execute_request === 1'b1) begin
      obsQ.push_back({gpu_command, gpu_x0, gpu_y0, gpu_x1, gpu_y1, gpu_colour});
      pulseCycle.push_back(cycleNo);
      if (gpu_busy) busyViol++;
      if (prevReq) b2bViol++;
      busyCnt = busyLen;
    end else if (busyCnt > 0) begin
      busyCnt--;
    end
    prevReq = (gpu_execute_request === 1'b1);
  end

  function automatic logic [ENT_W-1:0] mkEntry(input raster_command_t c,
      input logic [COORD_W-1:0] x0, input logic [COORD_W-1:0] y0,
      input logic [COORD_W-1:0] x1, input logic [COORD_W-1:0] y1,
      input logic [COLOUR_W-1:0] col);
    return {c, x0, y0, x1, y1, col};
  endfunction

  // Drives one push for a single edge; keep says whether the bench expects it issued.
  task automatic applyStimulus(input logic [ENT_W-1:0] e, input bit keep);
    logic [2:0] cmdBits;
    {cmdBits, in_x0, in_y0, in_x1, in_y1, in_colour} = e;
    in_command = raster_command_t'(cmdBits);
    push = 1'b1;
    if (keep) expQ.push_back(e);
    @(negedge clk);
    push = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    vecCount++;
    if (empty !== 1'b1) begin errCount++; $display("[TB] FAIL reset_empty: got %b want 1", empty); end
    vecCount++;
    if (full !== 1'b0) begin errCount++; $display("[TB] FAIL reset_full: got %b want 0", full); end
    vecCount++;
    if (count !== '0) begin errCount++; $display("[TB] FAIL reset_count: got %0d want 0", count); end
    vecCount++;
    if (overflow !== 1'b0) begin errCount++; $display("[TB] FAIL reset_overflow: got %b want 0", overflow); end
    vecCount++;
    if (gpu_execute_request !== 1'b0) begin errCount++; $display("[TB] FAIL reset_req: got %b want 0", gpu_execute_request); end
    vecCount++;
    if ({gpu_command, gpu_x0, gpu_y0, gpu_x1, gpu_y1, gpu_colour} !== '0) begin
      errCount++; $display("[TB] FAIL reset_gpu_fields: got %h want 0", {gpu_command, gpu_x0, gpu_y0, gpu_x1, gpu_y1, gpu_colour});
    end
    repeat (2) @(negedge clk);
    rst_async = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_command();
    logic [ENT_W-1:0] got, want;
    busyLen = 3;
    applyStimulus(mkEntry(RC_POINT, 8'd100, 8'd100, 8'd0, 8'd0, 3'b110), 1'b1);
    vecCount++;
    if (count !== CNT_W'(1)) begin errCount++; $display("[TB] FAIL single_count_after_push: got %0d want 1", count); end
    vecCount++;
    if (gpu_execute_request !== 1'b0) begin errCount++; $display("[TB] FAIL single_req_early: got %b want 0", gpu_execute_request); end
    @(negedge clk);
    vecCount++;
    if (gpu_execute_request !== 1'b1) begin errCount++; $display("[TB] FAIL single_req_pulse: got %b want 1", gpu_execute_request); end
    @(negedge clk);
    vecCount++;
    if (gpu_execute_request !== 1'b0) begin errCount++; $display("[TB] FAIL single_req_width: got %b want 0", gpu_execute_request); end
    repeat (8) @(negedge clk);
    vecCount++;
    if (count !== '0) begin errCount++; $display("[TB] FAIL single_count_final: got %0d want 0", count); end
    vecCount++;
    if (gpu_x0 !== 8'd100 || gpu_y0 !== 8'd100 || gpu_colour !== 3'b110) begin
      errCount++; $display("[TB] FAIL single_fields: got x0=%0d y0=%0d col=%b want 100 100 110", gpu_x0, gpu_y0, gpu_colour);
    end
    while (readIdx < obsQ.size()) begin
      got = obsQ[readIdx]; readIdx++; vecCount++;
      if (expQ.size() == 0) begin errCount++; $display("[TB] FAIL single_issue: got %h want none", got); end
      else begin want = expQ.pop_front();
        if (got !== want) begin errCount++; $display("[TB] FAIL single_issue: got %h want %h", got, want); end end
    end
    vecCount++;
    if (expQ.size() != 0) begin errCount++; $display("[TB] FAIL single_missing: got %0d pending want 0", expQ.size()); end
  endtask

  task automatic test_busy_backpressure();
    logic [ENT_W-1:0] got, want;
    int base, waited, gap;
    busyLen = 20;
    base = obsQ.size();
    for (int i = 0; i < 3; i++)
      applyStimulus(mkEntry(RC_LINE, 8'(i*10), 8'(i*10+1), 8'(i*10+2), 8'(i*10+3), 3'(i+1)), 1'b1);
    waited = 0;
    while (obsQ.size() - base < 3 && waited < 300) begin @(negedge clk); waited++; end
    vecCount++;
    if (obsQ.size() - base != 3) begin errCount++; $display("[TB] FAIL bp_pulse_count: got %0d want 3", obsQ.size() - base); end
    for (int i = 1; i < 3; i++) begin
      if (base + i < pulseCycle.size()) begin
        gap = pulseCycle[base+i] - pulseCycle[base+i-1];
        vecCount++;
        if (gap <= busyLen) begin errCount++; $display("[TB] FAIL bp_gap%0d: got %0d cycles want >%0d", i, gap, busyLen); end
      end
    end
    while (readIdx < obsQ.size()) begin
      got = obsQ[readIdx]; readIdx++; vecCount++;
      if (expQ.size() == 0) begin errCount++; $display("[TB] FAIL bp_issue: got %h want none", got); end
      else begin want = expQ.pop_front();
        if (got !== want) begin errCount++; $display("[TB] FAIL bp_issue: got %h want %h", got, want); end end
    end
    vecCount++;
    if (busyViol != 0) begin errCount++; $display("[TB] FAIL bp_issue_while_busy: got %0d want 0", busyViol); end
    vecCount++;
    if (b2bViol != 0) begin errCount++; $display("[TB] FAIL bp_req_consecutive: got %0d want 0", b2bViol); end
    repeat (30) @(negedge clk);
  endtask

  task automatic test_overflow();
    logic [ENT_W-1:0] got, want;
    int waited;
    forceBusy = 1'b1;
    busyLen = 2;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(mkEntry(RC_RECT, 8'(40+i), 8'(60+i), 8'(80+i), 8'(90+i), 3'(i)), i < DEPTH);
      vecCount++;
      if (count !== CNT_W'((i < DEPTH) ? i+1 : DEPTH)) begin
        errCount++; $display("[TB] FAIL ovf_count_%0d: got %0d want %0d", i, count, (i < DEPTH) ? i+1 : DEPTH);
      end
      vecCount++;
      if (overflow !== (i >= DEPTH)) begin
        errCount++; $display("[TB] FAIL ovf_flag_%0d: got %b want %b", i, overflow, (i >= DEPTH));
      end
    end
    vecCount++;
    if (full !== 1'b1) begin errCount++; $display("[TB] FAIL ovf_full: got %b want 1", full); end
    clear_overflow = 1'b1;
    @(negedge clk);
    clear_overflow = 1'b0;
    vecCount++;
    if (overflow !== 1'b0) begin errCount++; $display("[TB] FAIL ovf_clear: got %b want 0", overflow); end
    forceBusy = 1'b0;
    waited = 0;
    while (expQ.size() > obsQ.size() - readIdx && waited < 300) begin @(negedge clk); waited++; end
    repeat (40) @(negedge clk);
    while (readIdx < obsQ.size()) begin
      got = obsQ[readIdx]; readIdx++; vecCount++;
      if (expQ.size() == 0) begin errCount++; $display("[TB] FAIL ovf_issue: got %h want none", got); end
      else begin want = expQ.pop_front();
        if (got !== want) begin errCount++; $display("[TB] FAIL ovf_issue: got %h want %h", got, want); end end
    end
    vecCount++;
    if (expQ.size() != 0) begin errCount++; $display("[TB] FAIL ovf_missing: got %0d pending want 0", expQ.size()); end
  endtask

  task automatic test_flush_with_push();
    logic [ENT_W-1:0] got, want, first;
    busyLen = 40;
    first = mkEntry(RC_FILL_RECT, 8'd11, 8'd22, 8'd33, 8'd44, 3'b101);
    applyStimulus(first, 1'b1);
    for (int i = 0; i < 5; i++)
      applyStimulus(mkEntry(RC_CIRCLE, 8'(150+i), 8'd1, 8'd2, 8'd3, 3'b010), 1'b0);
    vecCount++;
    if (count !== CNT_W'(5)) begin errCount++; $display("[TB] FAIL flush_precount: got %0d want 5", count); end
    flush = 1'b1;
    applyStimulus(mkEntry(RC_CLEAR, 8'd7, 8'd7, 8'd7, 8'd7, 3'b111), 1'b0);
    flush = 1'b0;
    vecCount++;
    if (count !== '0) begin errCount++; $display("[TB] FAIL flush_count: got %0d want 0", count); end
    vecCount++;
    if (empty !== 1'b1) begin errCount++; $display("[TB] FAIL flush_empty: got %b want 1", empty); end
    vecCount++;
    if (overflow !== 1'b0) begin errCount++; $display("[TB] FAIL flush_overflow: got %b want 0", overflow); end
    vecCount++;
    if ({gpu_command, gpu_x0, gpu_y0, gpu_x1, gpu_y1, gpu_colour} !== first) begin
      errCount++; $display("[TB] FAIL flush_inflight: got %h want %h", {gpu_command, gpu_x0, gpu_y0, gpu_x1, gpu_y1, gpu_colour}, first);
    end
    repeat (60) @(negedge clk);
    while (readIdx < obsQ.size()) begin
      got = obsQ[readIdx]; readIdx++; vecCount++;
      if (expQ.size() == 0) begin errCount++; $display("[TB] FAIL flush_issue: got %h want none", got); end
      else begin want = expQ.pop_front();
        if (got !== want) begin errCount++; $display("[TB] FAIL flush_issue: got %h want %h", got, want); end end
    end
    vecCount++;
    if (expQ.size() != 0) begin errCount++; $display("[TB] FAIL flush_missing: got %0d pending want 0", expQ.size()); end
  endtask

  task automatic test_wrap_around();
    logic [ENT_W-1:0] got, want;
    int sent, guard;
    busyLen = 1;
    sent = 0;
    guard = 0;
    while (sent < 20 && guard < 400) begin
      if (full === 1'b0) begin
        applyStimulus(mkEntry(RC_LINE, 8'(sent), 8'(200-sent), 8'(sent*3), 8'd9, 3'(sent)), 1'b1);
        sent++;
      end else begin
        @(negedge clk);
      end
      guard++;
    end
    guard = 0;
    while (expQ.size() > 0 && guard < 400) begin
      @(negedge clk);
      guard++;
      while (readIdx < obsQ.size()) begin
        got = obsQ[readIdx]; readIdx++; vecCount++;
        if (expQ.size() == 0) begin errCount++; $display("[TB] FAIL wrap_issue: got %h want none", got); end
        else begin want = expQ.pop_front();
          if (got !== want) begin errCount++; $display("[TB] FAIL wrap_issue: got %h want %h", got, want); end end
      end
    end
    vecCount++;
    if (sent != 20 || expQ.size() != 0) begin
      errCount++; $display("[TB] FAIL wrap_complete: got sent=%0d pending=%0d want 20 0", sent, expQ.size());
    end
    vecCount++;
    if (overflow !== 1'b0) begin errCount++; $display("[TB] FAIL wrap_overflow: got %b want 0", overflow); end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_mid_operation();
    logic [ENT_W-1:0] got, want;
    int base, waited;
    busyLen = 50;
    applyStimulus(mkEntry(RC_RECT, 8'd5, 8'd6, 8'd7, 8'd8, 3'b001), 1'b1);
    for (int i = 0; i < 3; i++)
      applyStimulus(mkEntry(RC_POINT, 8'(90+i), 8'd0, 8'd0, 8'd0, 3'b011), 1'b0);
    repeat (2) @(negedge clk);
    vecCount++;
    if (count !== CNT_W'(3)) begin errCount++; $display("[TB] FAIL rst_precount: got %0d want 3", count); end
    forceBusy = 1'b1;
    #3 rst_async = 1'b1;
    #1;
    vecCount++;
    if (empty !== 1'b1 || full !== 1'b0 || count !== '0) begin
      errCount++; $display("[TB] FAIL rst_mid_fifo: got empty=%b full=%b count=%0d want 1 0 0", empty, full, count);
    end
    vecCount++;
    if (overflow !== 1'b0 || gpu_execute_request !== 1'b0) begin
      errCount++; $display("[TB] FAIL rst_mid_flags: got ovf=%b req=%b want 0 0", overflow, gpu_execute_request);
    end
    vecCount++;
    if ({gpu_command, gpu_x0, gpu_y0, gpu_x1, gpu_y1, gpu_colour} !== '0) begin
      errCount++; $display("[TB] FAIL rst_mid_fields: got %h want 0", {gpu_command, gpu_x0, gpu_y0, gpu_x1, gpu_y1, gpu_colour});
    end
    while (readIdx < obsQ.size()) begin
      got = obsQ[readIdx]; readIdx++; vecCount++;
      if (expQ.size() == 0) begin errCount++; $display("[TB] FAIL rst_issue_pre: got %h want none", got); end
      else begin want = expQ.pop_front();
        if (got !== want) begin errCount++; $display("[TB] FAIL rst_issue_pre: got %h want %h", got, want); end end
    end
    @(negedge clk);
    rst_async = 1'b0;
    base = obsQ.size();
    repeat (10) @(negedge clk);
    applyStimulus(mkEntry(RC_FILL_CIRCLE, 8'd123, 8'd45, 8'd67, 8'd89, 3'b100), 1'b1);
    repeat (5) @(negedge clk);
    vecCount++;
    if (obsQ.size() != base) begin errCount++; $display("[TB] FAIL rst_no_issue_busy: got %0d pulses want 0", obsQ.size() - base); end
    forceBusy = 1'b0;
    waited = 0;
    while (obsQ.size() == base && waited < 150) begin @(negedge clk); waited++; end
    repeat (5) @(negedge clk);
    while (readIdx < obsQ.size()) begin
      got = obsQ[readIdx]; readIdx++; vecCount++;
      if (expQ.size() == 0) begin errCount++; $display("[TB] FAIL rst_issue_post: got %h want none", got); end
      else begin want = expQ.pop_front();
        if (got !== want) begin errCount++; $display("[TB] FAIL rst_issue_post: got %h want %h", got, want); end end
    end
    vecCount++;
    if (expQ.size() != 0) begin errCount++; $display("[TB] FAIL rst_missing: got %0d pending want 0", expQ.size()); end
    vecCount++;
    if (busyViol != 0 || b2bViol != 0) begin
      errCount++; $display("[TB] FAIL rst_protocol: got busyViol=%0d b2b=%0d want 0 0", busyViol, b2bViol);
    end
  endtask

  initial begin
    test_reset();
    test_single_command();
    test_busy_backpressure();
    test_overflow();
    test_flush_with_push();
    test_wrap_around();
    test_reset_mid_operation();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
